// File: rtl/func_link_pkg.sv
// ----------------------------------------------------------------------------
// func_link_pkg
//
// Purpose:
//   Shared definitions for both ends of the interface-function serial link.
//   The transmitter (transmissor_funcao) and the remote receiver use this
//   package so that state encoding, line levels and the default code width
//   always agree.
//
// Contents:
//   tx_state_t           frame state machine encoding (3 bits)
//   LINE_IDLE            level driven while no frame is in flight
//   START_BIT            level of the start bit
//   STOP_BIT             level of the stop bit
//   DEFAULT_FUNC_W       default width of the function code
//   DEFAULT_CLKS_PER_BIT default number of clocks each serial bit is held
//   cnt_width()          width of a counter that must hold 0..n-1 (min 1)
//
// Configuration:
//   PARITY_EN (macro) selects the even-parity frame in the users of this
//   package. The PARITY encoding is always reserved here so both ends keep
//   the same state numbering.
// ----------------------------------------------------------------------------
package func_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEFAULT_FUNC_W       = 3;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // A counter for 0..n-1 needs clog2(n) bits, but never fewer than one,
    // otherwise a single-bit code would produce a zero-width vector.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end
        return 1;
    endfunction

endpackage

// File: rtl/temporizador_bit.sv
// ----------------------------------------------------------------------------
// temporizador_bit
//
// Purpose:
//   Bit-period timer for the serial transmitter. A down-counter that runs
//   from CLKS_PER_BIT-1 to 0 while enabled. When it sits at 0, bit_tick is
//   asserted for that cycle and the counter reloads, so every bit period is
//   exactly CLKS_PER_BIT cycles long, including CLKS_PER_BIT = 1 where the
//   reload value is 0 and bit_tick is asserted every enabled cycle.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit, legal range 1..255
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous reset, active low (clears the count)
//   load       in   1   reload to CLKS_PER_BIT-1 (start of a new frame)
//   en         in   1   count while a frame is in flight
//   bit_tick   out  1   current cycle is the last cycle of a bit period
//   last_next  out  1   the count after the next edge will be 0, i.e. the
//                       coming cycle is the last cycle of its bit period
// ----------------------------------------------------------------------------
module temporizador_bit
    import func_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic bit_tick,
    output logic last_next
);

    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

    logic [7:0] count;
    logic [7:0] count_next;

    assign bit_tick = en && (count == 8'd0);

    // Reload has priority over counting down: at the end of a bit period the
    // counter jumps straight back to the top instead of underflowing, and a
    // new frame always starts from a full period.
    always_comb begin
        count_next = count;
        if (load || bit_tick) begin
            count_next = RELOAD;
        end else if (en) begin
            count_next = count - 8'd1;
        end
    end

    // Looking at the next count lets the owner register outputs that must be
    // valid during the last cycle of a bit period.
    assign last_next = (count_next == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/transmissor_funcao.sv
// ----------------------------------------------------------------------------
// transmissor_funcao
//
// Purpose:
//   Sending end of the interface-function link. Latches a FUNC_W-bit
//   function code on request and serializes it on one wire:
//     start(0), data LSB first, [even parity], stop(1); line idles high.
//   Each bit is held for CLKS_PER_BIT clock cycles.
//
// Parameters:
//   FUNC_W        width of the function code (bit0 is sent first)
//   CLKS_PER_BIT  clocks per serial bit, legal range 1..255
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous reset, active low
//   func_in    in   FUNC_W  function code, sampled only when a send is accepted
//   send       in   1       request to transmit func_in
//   ready      out  1       1 = can accept a send (idle or last stop cycle)
//   tx_serial  out  1       serial line to the remote interface
//   done       out  1       one-cycle pulse in the last stop-bit cycle
//
// Configuration:
//   PARITY_EN  when defined, an even-parity bit (XOR of the latched code) is
//              inserted between the data bits and the stop bit. When not
//              defined the PARITY state is unused and DATA goes to STOP.
//              The remote receiver must be built with the same setting.
//
// All outputs come straight from flops; the next values are computed from
// the next state so that they line up with the state they describe.
// ----------------------------------------------------------------------------
module transmissor_funcao
    import func_link_pkg::*;
#(
    parameter int FUNC_W       = DEFAULT_FUNC_W,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FUNC_W-1:0] func_in,
    input  logic              send,
    output logic              ready,
    output logic              tx_serial,
    output logic              done
);

    localparam int              BIT_W    = cnt_width(FUNC_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FUNC_W - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [FUNC_W-1:0] shift_reg;
    logic [FUNC_W-1:0] shift_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_next;
`ifdef PARITY_EN
    logic              parity_reg;
    logic              parity_next;
`endif

    logic              tx_next;
    logic              done_next;
    logic              ready_next;

    logic              accept;
    logic              timer_en;
    logic              bit_tick;
    logic              last_next;

    // A request is taken only when ready is already high; anything arriving
    // while a frame is in flight is dropped, there is no queue.
    assign accept   = send && ready;
    assign timer_en = (state != IDLE);

    temporizador_bit #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_temporizador_bit (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .en        (timer_en),
        .bit_tick  (bit_tick),
        .last_next (last_next)
    );

    // State register plus the registered outputs. Reset drops the frame in
    // flight and returns the line to idle immediately, without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
`ifdef PARITY_EN
            parity_reg <= 1'b0;
`endif
            tx_serial  <= LINE_IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_cnt    <= bit_cnt_next;
`ifdef PARITY_EN
            parity_reg <= parity_next;
`endif
            tx_serial  <= tx_next;
            ready      <= ready_next;
            done       <= done_next;
        end
    end

    // Next-state logic. The code is latched on accept, which can happen in
    // IDLE or in the last STOP cycle; in the latter case START follows
    // directly so back-to-back frames have no idle bit between them. The
    // parity is computed from the code at accept because the shift register
    // no longer holds all data bits by the time the parity bit is sent.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
`ifdef PARITY_EN
        parity_next  = parity_reg;
`endif

        if (accept) begin
            shift_next   = func_in;
            bit_cnt_next = '0;
`ifdef PARITY_EN
            parity_next  = ^func_in;
`endif
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
`ifdef PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_next = accept ? START : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs describe
    // the cycle that state_next will occupy. done and ready rise together in
    // the last stop cycle so a new send can be taken without a gap.
    always_comb begin
        tx_next = LINE_IDLE;
        case (state_next)
            START:   tx_next = START_BIT;
            DATA:    tx_next = shift_next[0];
`ifdef PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            STOP:    tx_next = STOP_BIT;
            default: tx_next = LINE_IDLE;
        endcase

        done_next  = (state_next == STOP) && last_next;
        ready_next = (state_next == IDLE) || done_next;
    end

endmodule

// File: tb/tb_transmissor_funcao.sv
// ----------------------------------------------------------------------------
// tb_transmissor_funcao
//
// Two transmitters side by side: dut0 with the default 4 clocks per bit and
// dut1 with 1 clock per bit. Every accepted frame pushes its expected
// per-cycle line/done/ready values into that DUT's queue; a monitor on each
// DUT pops one entry per cycle and, when the queue is empty, expects an idle
// line. Follows PARITY_EN when building the expected frames.
// ----------------------------------------------------------------------------
module tb_transmissor_funcao;

    localparam int FW = 3;

    typedef struct packed {
        logic tx;
        logic done;
        logic ready;
    } exp_t;

    localparam exp_t IDLE_EXP = '{tx: 1'b1, done: 1'b0, ready: 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n0, send0, ready0, tx0, done0;
    logic [FW-1:0] func0;
    logic          rst_n1, send1, ready1, tx1, done1;
    logic [FW-1:0] func1;

    int   errors = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    bit   mon0 = 1'b0;
    bit   mon1 = 1'b0;
    int   done_cnt0 = 0;
    int   done_cnt1 = 0;

    transmissor_funcao #(
        .FUNC_W       (FW),
        .CLKS_PER_BIT (4)
    ) dut0 (
        .clk       (clk),
        .rst_n     (rst_n0),
        .func_in   (func0),
        .send      (send0),
        .ready     (ready0),
        .tx_serial (tx0),
        .done      (done0)
    );

    transmissor_funcao #(
        .FUNC_W       (FW),
        .CLKS_PER_BIT (1)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n1),
        .func_in   (func1),
        .send      (send1),
        .ready     (ready1),
        .tx_serial (tx1),
        .done      (done1)
    );

    // Scoreboard monitor for dut0, sampled on the falling edge.
    always @(negedge clk) begin
        if (done0 === 1'b1) done_cnt0++;
        if (mon0) begin
            if (q0.size() > 0) e0 = q0.pop_front();
            else               e0 = IDLE_EXP;
            checks++;
            if ({tx0, done0, ready0} !== e0) begin
                errors++;
                $display("[TB] FAIL line0 at %0t: tx/done/ready got %b%b%b expected %b%b%b",
                         $time, tx0, done0, ready0, e0.tx, e0.done, e0.ready);
            end
        end
    end

    // Scoreboard monitor for dut1, sampled on the falling edge.
    always @(negedge clk) begin
        if (done1 === 1'b1) done_cnt1++;
        if (mon1) begin
            if (q1.size() > 0) e1 = q1.pop_front();
            else               e1 = IDLE_EXP;
            checks++;
            if ({tx1, done1, ready1} !== e1) begin
                errors++;
                $display("[TB] FAIL line1 at %0t: tx/done/ready got %b%b%b expected %b%b%b",
                         $time, tx1, done1, ready1, e1.tx, e1.done, e1.ready);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int cpb(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    function automatic int flen(input int sel);
        int nbits;
        nbits = FW + 2;
`ifdef PARITY_EN
        nbits = nbits + 1;
`endif
        return nbits * cpb(sel);
    endfunction

    function automatic logic [2:0] outs(input int sel);
        if (sel == 0) return {tx0, done0, ready0};
        return {tx1, done1, ready1};
    endfunction

    function automatic int dcnt(input int sel);
        return (sel == 0) ? done_cnt0 : done_cnt1;
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic s, input logic [FW-1:0] f);
        if (sel == 0) begin
            send0 = s;
            func0 = f;
        end else begin
            send1 = s;
            func1 = f;
        end
    endtask

    task automatic set_reset(input int sel, input logic r);
        if (sel == 0) rst_n0 = r;
        else          rst_n1 = r;
    endtask

    task automatic set_mon(input int sel, input bit m);
        if (sel == 0) mon0 = m;
        else          mon1 = m;
    endtask

    // Expected frame built from the framing rules: start, data LSB first,
    // optional even parity, stop; done and ready only in the very last cycle.
    task automatic push_frame(input int sel, input logic [FW-1:0] code);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < FW; i++) bits.push_back(code[i]);
`ifdef PARITY_EN
        bits.push_back(^code);
`endif
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < cpb(sel); c++) begin
                e.tx    = bits[b];
                e.done  = (b == bits.size() - 1) && (c == cpb(sel) - 1);
                e.ready = e.done;
                if (sel == 0) q0.push_back(e);
                else          q1.push_back(e);
            end
        end
    endtask

    // Called at posedge+1 while the DUT is ready; returns in cycle 1 of the frame.
    task automatic send_code(input int sel, input logic [FW-1:0] code);
        applyStimulus(sel, 1'b1, code);
        tick(1);
        applyStimulus(sel, 1'b0, code);
        push_frame(sel, code);
    endtask

    task automatic test_reset();
        int d0, d1;
        $display("[TB] test_reset");
        applyStimulus(0, 1'b1, 3'b101);
        applyStimulus(1, 1'b1, 3'b101);
        tick(3);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (outs(s) !== 3'b101) begin
                errors++;
                $display("[TB] FAIL reset_hold dut%0d: tx/done/ready got %b expected 101", s, outs(s));
            end
        end
        set_reset(0, 1'b1);
        set_reset(1, 1'b1);
        #2;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (outs(s) !== 3'b101) begin
                errors++;
                $display("[TB] FAIL reset_release dut%0d: tx/done/ready got %b expected 101", s, outs(s));
            end
        end
        d0 = done_cnt0;
        d1 = done_cnt1;
        tick(1);
        applyStimulus(0, 1'b0, 3'b101);
        applyStimulus(1, 1'b0, 3'b101);
        push_frame(0, 3'b101);
        push_frame(1, 3'b101);
        mon0 = 1'b1;
        mon1 = 1'b1;
        tick(flen(0) + 3);
        checks++;
        if ((done_cnt0 - d0) != 1 || (done_cnt1 - d1) != 1) begin
            errors++;
            $display("[TB] FAIL reset_first_frame done pulses got %0d/%0d expected 1/1",
                     done_cnt0 - d0, done_cnt1 - d1);
        end
    endtask

    task automatic test_basic(input int sel);
        int d;
        $display("[TB] test_basic dut%0d", sel);
        d = dcnt(sel);
        send_code(sel, 3'b101);
        tick(flen(sel) + 3);
        checks++;
        if (dcnt(sel) - d != 1) begin
            errors++;
            $display("[TB] FAIL basic_done dut%0d: pulses got %0d expected 1", sel, dcnt(sel) - d);
        end
        checks++;
        if (qsize(sel) != 0) begin
            errors++;
            $display("[TB] FAIL basic_drain dut%0d: %0d expected cycles left, expected 0", sel, qsize(sel));
        end
    endtask

    task automatic test_codes();
        int d;
        $display("[TB] test_codes");
        d = done_cnt0;
        send_code(0, 3'b011);
        applyStimulus(0, 1'b0, 3'b100);
        tick(flen(0) + 2);
        send_code(0, 3'b111);
        applyStimulus(0, 1'b0, 3'b000);
        tick(flen(0) + 2);
        checks++;
        if (done_cnt0 - d != 2) begin
            errors++;
            $display("[TB] FAIL codes_done: pulses got %0d expected 2", done_cnt0 - d);
        end
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("[TB] FAIL codes_drain: %0d cycles left, expected 0", q0.size());
        end
    endtask

    task automatic test_back_to_back();
        int d;
        $display("[TB] test_back_to_back");
        d = done_cnt0;
        applyStimulus(0, 1'b1, 3'b001);
        tick(1);
        applyStimulus(0, 1'b1, 3'b110);
        push_frame(0, 3'b001);
        push_frame(0, 3'b110);
        tick(flen(0));
        applyStimulus(0, 1'b0, 3'b110);
        tick(flen(0) + 3);
        checks++;
        if (done_cnt0 - d != 2) begin
            errors++;
            $display("[TB] FAIL b2b_done: pulses got %0d expected 2", done_cnt0 - d);
        end
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: %0d cycles left, expected 0", q0.size());
        end
    endtask

    task automatic test_ignored();
        int d;
        $display("[TB] test_ignored");
        d = done_cnt0;
        send_code(0, 3'b000);
        tick(6);
        applyStimulus(0, 1'b1, 3'b111);
        tick(1);
        applyStimulus(0, 1'b0, 3'b111);
        tick(flen(0) + 3);
        checks++;
        if (done_cnt0 - d != 1) begin
            errors++;
            $display("[TB] FAIL ignored_done: pulses got %0d expected 1", done_cnt0 - d);
        end
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("[TB] FAIL ignored_drain: %0d cycles left, expected 0", q0.size());
        end
    endtask

    task automatic test_abort(input int sel);
        int d;
        $display("[TB] test_abort dut%0d", sel);
        send_code(sel, 3'b101);
        tick(2 * cpb(sel));
        set_mon(sel, 1'b0);
        if (sel == 0) q0.delete();
        else          q1.delete();
        d = dcnt(sel);
        set_reset(sel, 1'b0);
        #1;
        checks++;
        if (outs(sel) !== 3'b101) begin
            errors++;
            $display("[TB] FAIL abort_immediate dut%0d: tx/done/ready got %b expected 101", sel, outs(sel));
        end
        tick(2);
        checks++;
        if (outs(sel) !== 3'b101) begin
            errors++;
            $display("[TB] FAIL abort_held dut%0d: tx/done/ready got %b expected 101", sel, outs(sel));
        end
        set_reset(sel, 1'b1);
        set_mon(sel, 1'b1);
        tick(flen(sel));
        checks++;
        if (dcnt(sel) != d) begin
            errors++;
            $display("[TB] FAIL abort_no_done dut%0d: pulses got %0d expected 0", sel, dcnt(sel) - d);
        end
        send_code(sel, 3'b010);
        tick(flen(sel) + 3);
        checks++;
        if (dcnt(sel) - d != 1) begin
            errors++;
            $display("[TB] FAIL abort_recover dut%0d: pulses got %0d expected 1", sel, dcnt(sel) - d);
        end
        checks++;
        if (qsize(sel) != 0) begin
            errors++;
            $display("[TB] FAIL abort_drain dut%0d: %0d cycles left, expected 0", sel, qsize(sel));
        end
    endtask

    initial begin
        send0  = 1'b0;
        send1  = 1'b0;
        func0  = '0;
        func1  = '0;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;

        test_reset();
        test_basic(0);
        test_basic(1);
        test_codes();
        test_back_to_back();
        test_ignored();
        test_abort(0);
        test_abort(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
